profiler_snapshot_controller: RTL

- Sequences profiling sessions for the counter units (cache, branch, stall profilers): drives their shared enable, issues periodic snapshot strobes, and serialises snapshotted counters into a framed byte stream for the host link (UART/debug FIFO).
- Sits between the profiler units, behind a counter-select mux, and the transmit interface.
- Replaces per-unit free-running snapshot timers with one central scheduler.

---
 rtl/profiler_snapshot_controller.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/profiler_snapshot_controller.sv
// profiler_snapshot_controller
//   Central scheduler for the profiler counter units. Gates the shared
//   profiler enable, issues one snapshot strobe per window, and streams each
//   snapshot out as a framed byte sequence:
//     0xA5, seq_num, NUM_COUNTERS x 4 bytes (counter 0 first, MSB first),
//     XOR checksum of all preceding frame bytes.
//
// Ports
//   clk_i / rst_i           : clock, synchronous active-high reset
//   cmd_start_i             : pulse, begin continuous session
//   cmd_single_i            : pulse, one window, one frame, then stop
//   cmd_stop_i              : pulse, end session (after current frame)
//   prof_enable_o           : profiler enable; low clears their counters
//   snapshot_strobe_o       : one-cycle pulse, profilers latch shadows
//   counter_sel_o           : shadow mux select
//   counter_data_i          : muxed shadow value, valid one cycle after sel
//   tx_data_o/tx_valid_o    : stream byte / valid
//   tx_ready_i              : sink accepts byte
//   busy_o                  : any state other than IDLE
//   overrun_o               : sticky, a window expired mid-frame
//   seq_num_o               : sequence number of the last frame started
module profiler_snapshot_controller #(
  parameter int NUM_COUNTERS  = 8,
  parameter int SEL_WIDTH     = 3,
  parameter int WINDOW_CYCLES = 200000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_start,
  input  logic                 cmd_single,
  input  logic                 cmd_stop,
  output logic                 prof_enable,
  output logic                 snapshot_strobe,
  output logic [SEL_WIDTH-1:0] counter_sel,
  input  logic [31:0]          counter_data,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 overrun,
  output logic [7:0]           seq_num
);

  localparam int TW = $clog2(WINDOW_CYCLES);
  localparam logic [TW-1:0]        T_LAST   = TW'(WINDOW_CYCLES - 1);
  localparam logic [SEL_WIDTH-1:0] SEL_LAST = SEL_WIDTH'(NUM_COUNTERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_SEND} state_t;
  typedef enum logic [2:0] {F_HDR, F_SEQ, F_DATA, F_CSUM, F_DONE} fphase_t;

  state_t               state_q;
  fphase_t              fphase_q;
  logic [TW-1:0]        timer_q;
  logic [TW-1:0]        timer_d;
  logic                 timer_last;
  logic                 cont_q;
  logic                 stop_pend_q;
  logic                 strobe_q;
  logic [SEL_WIDTH-1:0] sel_q;
  logic [1:0]           byte_q;
  logic                 wait_q;
  logic                 adv_q;
  logic [7:0]           cs_q;
  logic [7:0]           tx_data_q;
  logic                 tx_valid_q;
  logic                 overrun_q;
  logic [7:0]           seq_q;
  logic [7:0]           cur_byte;

  always_comb begin
    timer_last = (timer_q == T_LAST);
    timer_d    = timer_last ? '0 : timer_q + TW'(1);
  end

  always_comb begin
    cur_byte = '0;
    case (byte_q)
      2'd0:    cur_byte = counter_data[31:24];
      2'd1:    cur_byte = counter_data[23:16];
      2'd2:    cur_byte = counter_data[15:8];
      default: cur_byte = counter_data[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fphase_q    <= F_HDR;
      timer_q     <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      strobe_q    <= 1'b0;
      sel_q       <= '0;
      byte_q      <= '0;
      wait_q      <= 1'b0;
      adv_q       <= 1'b0;
      cs_q        <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      seq_q       <= '0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          timer_q <= '0;
          if (!cmd_stop && (cmd_start || cmd_single)) begin
            state_q     <= S_CLEAR;
            cont_q      <= cmd_start;
            stop_pend_q <= 1'b0;
          end
        end

        S_CLEAR: begin
          timer_q   <= '0;
          overrun_q <= 1'b0;
          if (cmd_stop) stop_pend_q <= 1'b1;
          state_q <= S_RUN;
        end

        S_RUN: begin
          if (cmd_stop) begin
            state_q <= S_IDLE;
            timer_q <= '0;
          end else begin
            timer_q <= timer_d;
            if (timer_last) begin
              // Strobe shows in the first SEND cycle; wait_q holds off the
              // first load so the freshly latched shadows settle.
              strobe_q   <= 1'b1;
              seq_q      <= seq_q + 8'd1;
              sel_q      <= '0;
              fphase_q   <= F_HDR;
              byte_q     <= '0;
              cs_q       <= '0;
              wait_q     <= 1'b1;
              adv_q      <= 1'b0;
              tx_valid_q <= 1'b0;
              state_q    <= S_SEND;
            end
          end
        end

        S_SEND: begin
          timer_q <= timer_d;
          if (timer_last) overrun_q <= 1'b1;
          if (cmd_stop) stop_pend_q <= 1'b1;
          // Output slot is free when empty or the current byte is taken.
          if (!tx_valid_q || tx_ready) begin
            if (adv_q) begin
              // Last byte of a counter accepted: move the mux, then idle
              // until the new value has propagated.
              sel_q      <= sel_q + SEL_WIDTH'(1);
              adv_q      <= 1'b0;
              wait_q     <= 1'b1;
              tx_valid_q <= 1'b0;
            end else if (wait_q) begin
              wait_q     <= 1'b0;
              tx_valid_q <= 1'b0;
            end else begin
              case (fphase_q)
                F_HDR: begin
                  tx_data_q  <= 8'hA5;
                  tx_valid_q <= 1'b1;
                  cs_q       <= 8'hA5;
                  fphase_q   <= F_SEQ;
                end
                F_SEQ: begin
                  tx_data_q  <= seq_q;
                  tx_valid_q <= 1'b1;
                  cs_q       <= cs_q ^ seq_q;
                  byte_q     <= '0;
                  fphase_q   <= F_DATA;
                end
                F_DATA: begin
                  tx_data_q  <= cur_byte;
                  tx_valid_q <= 1'b1;
                  cs_q       <= cs_q ^ cur_byte;
                  byte_q     <= byte_q + 2'd1;
                  if (byte_q == 2'd3) begin
                    if (sel_q == SEL_LAST) fphase_q <= F_CSUM;
                    else                   adv_q    <= 1'b1;
                  end
                end
                F_CSUM: begin
                  tx_data_q  <= cs_q;
                  tx_valid_q <= 1'b1;
                  fphase_q   <= F_DONE;
                end
                default: begin
                  tx_valid_q <= 1'b0;
                  sel_q      <= '0;
                  if (cont_q && !stop_pend_q && !cmd_stop) state_q <= S_RUN;
                  else                                     state_q <= S_IDLE;
                end
              endcase
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign prof_enable     = (state_q == S_RUN) || (state_q == S_SEND);
  assign busy            = (state_q != S_IDLE);
  assign snapshot_strobe = strobe_q;
  assign counter_sel     = sel_q;
  assign tx_data         = tx_data_q;
  assign tx_valid        = tx_valid_q;
  assign overrun         = overrun_q;
  assign seq_num         = seq_q;

endmodule
